// File: rtl/product_loader_pkg.sv
// Shared types and constants for the product loader.
// Dot-product feeder in front of the chunked accumulator.
package product_loader_pkg;

   localparam int VARWIDTH = 32;

   // FLOAT parameter values
   localparam bit FLOAT_INT  = 1'b0;
   localparam bit FLOAT_IEEE = 1'b1;

   typedef logic [VARWIDTH-1:0] word_t;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      ARM    = 2'd1,
      RUN    = 2'd2,
      RESULT = 2'd3
   } state_e;

endpackage

// File: rtl/product_loader_if.sv
// Pair stream, accumulator pins and result stream of the loader.
// slave = the loader itself, master = its environment.
interface product_loader_if
   import product_loader_pkg::*;
#(
   parameter int WIDTH = 16
) ();

   logic                      in_valid;
   logic                      in_ready;
   word_t                     in_data;
   word_t                     in_wt;
   logic                      in_last;
   logic                      acc_en;
   logic                      acc_rst;
   logic                      acc_pre;
   logic [VARWIDTH*WIDTH-1:0] acc_vals;
   logic                      acc_rdy;
   word_t                     acc_sum;
   logic                      res_valid;
   logic                      res_ready;
   word_t                     res_data;

   modport slave (
      input  in_valid, in_data, in_wt, in_last,
      input  acc_rdy, acc_sum, res_ready,
      output in_ready, acc_en, acc_rst, acc_pre,
      output acc_vals, res_valid, res_data
   );

   modport master (
      output in_valid, in_data, in_wt, in_last,
      output acc_rdy, acc_sum, res_ready,
      input  in_ready, acc_en, acc_rst, acc_pre,
      input  acc_vals, res_valid, res_data
   );

endinterface

// File: rtl/mul_f32.sv
// IEEE-754 single multiply, round to nearest even.
// Denormal inputs/results flush to zero; exp=255 inputs give infinity.
module mul_f32
   import product_loader_pkg::*;
(
   input  word_t a_i,
   input  word_t b_i,
   output word_t p_o
);

   logic        sgn;
   logic [47:0] mprod;
   logic [22:0] man;
   logic        grd;
   logic        stk;
   logic [9:0]  exp;
   logic [23:0] rnd;

   always_comb begin
      sgn   = a_i[31] ^ b_i[31];
      mprod = {24'b0, 1'b1, a_i[22:0]} * {24'b0, 1'b1, b_i[22:0]};
      exp   = {2'b0, a_i[30:23]} + {2'b0, b_i[30:23]} - 10'd127;
      man   = mprod[45:23];
      grd   = mprod[22];
      stk   = |mprod[21:0];
      if (mprod[47]) begin
         man = mprod[46:24];
         grd = mprod[23];
         stk = |mprod[22:0];
         exp = exp + 10'd1;
      end
      rnd = {1'b0, man} + {23'b0, grd & (stk | man[0])};
      man = rnd[22:0];
      exp = exp + {9'b0, rnd[23]};
      // exp bit 9 set means the biased exponent went negative
      if (a_i[30:23] == 8'd0 || b_i[30:23] == 8'd0)
         p_o = {sgn, 31'b0};
      else if (a_i[30:23] == 8'hFF || b_i[30:23] == 8'hFF)
         p_o = {sgn, 8'hFF, 23'b0};
      else if (exp[9] || exp == 10'd0)
         p_o = {sgn, 31'b0};
      else if (exp >= 10'd255)
         p_o = {sgn, 8'hFF, 23'b0};
      else
         p_o = {sgn, exp[7:0], man};
   end

endmodule

// File: rtl/product_loader_elem_mul32.sv
// One 32x32 element multiply: float via mul_f32, else
// signed integer keeping the low 32 bits.
module elem_mul32
   import product_loader_pkg::*;
#(
   parameter bit FLOAT = FLOAT_INT
) (
   input  word_t a_i,
   input  word_t b_i,
   output word_t prod_o
);

   generate
      if (FLOAT == FLOAT_IEEE) begin : g_flt
         mul_f32 u_mul (
            .a_i (a_i),
            .b_i (b_i),
            .p_o (prod_o)
         );
      end else begin : g_int
         // low half of a signed product equals the unsigned one
         assign prod_o = a_i * b_i;
      end
   endgenerate

endmodule

// File: rtl/product_loader.sv
// Packs pair products into WIDTH-slot chunks, sequences the
// accumulator over chained chunks and returns one result per dot product.
module product_loader
   import product_loader_pkg::*;
#(
   parameter bit FLOAT = FLOAT_INT,
   parameter int WIDTH = 16
) (
   input logic            clk,
   input logic            rst,
   product_loader_if.slave bus
);

   localparam int IW = $clog2(WIDTH) + 1;

   state_e          state_q;
   word_t           slot_q [WIDTH];
   logic [IW-1:0]   idx_q;
   logic            first_q;
   logic            last_q;
   logic            run1_q;
   logic            in_ready_q;
   logic            acc_en_q;
   logic            acc_rst_q;
   logic            acc_pre_q;
   logic            res_valid_q;
   word_t           res_data_q;

   word_t           prod;
   logic            accept;
   logic            full;

   elem_mul32 #(.FLOAT(FLOAT)) u_mul (
      .a_i    (bus.in_data),
      .b_i    (bus.in_wt),
      .prod_o (prod)
   );

   assign accept = bus.in_valid & in_ready_q;
   assign full   = (idx_q == IW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         idx_q       <= '0;
         first_q     <= 1'b1;
         last_q      <= 1'b0;
         run1_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         acc_en_q    <= 1'b0;
         acc_rst_q   <= 1'b1;
         acc_pre_q   <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         for (int k = 0; k < WIDTH; k++) slot_q[k] <= '0;
      end else begin
         unique case (state_q)
            FILL: begin
               acc_rst_q  <= 1'b0;
               in_ready_q <= 1'b1;
               if (accept) begin
                  slot_q[idx_q[IW-2:0]] <= prod;
                  idx_q <= idx_q + 1'b1;
                  if (full || bus.in_last) begin
                     last_q     <= bus.in_last;
                     in_ready_q <= 1'b0;
                     acc_rst_q  <= 1'b1;
                     acc_pre_q  <= ~first_q;
                     state_q    <= ARM;
                  end
               end
            end
            ARM: begin
               acc_rst_q <= 1'b0;
               acc_pre_q <= 1'b0;
               acc_en_q  <= 1'b1;
               run1_q    <= 1'b1;
               state_q   <= RUN;
            end
            RUN: begin
               // rdy left over from the previous chunk is masked by run1_q
               run1_q <= 1'b0;
               if (bus.acc_rdy && !run1_q) begin
                  acc_en_q <= 1'b0;
                  for (int k = 0; k < WIDTH; k++) slot_q[k] <= '0;
                  if (last_q) begin
                     res_data_q  <= bus.acc_sum;
                     res_valid_q <= 1'b1;
                     state_q     <= RESULT;
                  end else begin
                     first_q    <= 1'b0;
                     idx_q      <= '0;
                     in_ready_q <= 1'b1;
                     state_q    <= FILL;
                  end
               end
            end
            RESULT: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  first_q     <= 1'b1;
                  idx_q       <= '0;
                  in_ready_q  <= 1'b1;
                  state_q     <= FILL;
               end
            end
         endcase
      end
   end

   generate
      for (genvar k = 0; k < WIDTH; k++) begin : g_vals
         assign bus.acc_vals[VARWIDTH*k +: VARWIDTH] = slot_q[k];
      end
   endgenerate

   assign bus.in_ready  = in_ready_q;
   assign bus.acc_en    = acc_en_q;
   assign bus.acc_rst   = acc_rst_q;
   assign bus.acc_pre   = acc_pre_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;

endmodule
